// File: rtl/axi4_b_arbiter.sv
// axi4_b_arbiter: merges NUM_IN AXI4 write-response (B) channels onto one
// upstream B channel through a one-entry registered output stage.
// Arbitration is round-robin by default. Defining RAB_B_ARB_FIXED_PRIO_EN
// removes the priority pointer and makes the lowest-index valid source win.
//
// Handshake semantics (all channels): a transfer happens on a rising edge
// where valid and ready are both 1. A valid source keeps its payload stable
// until it sees ready. Upstream, once s_axi4_bvalid is 1 the payload
// (bid/bresp/buser/bsrc) is held until s_axi4_bvalid & s_axi4_bready.
// m_axi4_bready is one-hot or zero and is a function of m_axi4_bvalid,
// s_axi4_bready, reset and the register state only.
module axi4_b_arbiter #(
    parameter int AXI_ID_WIDTH   = 4,
    parameter int AXI_USER_WIDTH = 4,
    parameter int NUM_IN         = 2,
    parameter int SRC_W          = $clog2(NUM_IN)
) (
    input  logic                             axi4_aclk,
    input  logic                             axi4_arstn,
    input  logic [NUM_IN*AXI_ID_WIDTH-1:0]   m_axi4_bid,
    input  logic [NUM_IN*2-1:0]              m_axi4_bresp,
    input  logic [NUM_IN*AXI_USER_WIDTH-1:0] m_axi4_buser,
    input  logic [NUM_IN-1:0]                m_axi4_bvalid,
    output logic [NUM_IN-1:0]                m_axi4_bready,
    output logic [AXI_ID_WIDTH-1:0]          s_axi4_bid,
    output logic [1:0]                       s_axi4_bresp,
    output logic [AXI_USER_WIDTH-1:0]        s_axi4_buser,
    output logic                             s_axi4_bvalid,
    input  logic                             s_axi4_bready,
    output logic [SRC_W-1:0]                 s_axi4_bsrc
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t                      state;
    logic                        can_load;
    logic                        load_fire;
    logic                        grant_any;
    logic [SRC_W-1:0]            grant_idx;
    logic [AXI_ID_WIDTH-1:0]     sel_id;
    logic [1:0]                  sel_resp;
    logic [AXI_USER_WIDTH-1:0]   sel_user;

    // The register state is the upstream valid; it is visible on the port.
    assign s_axi4_bvalid = (state == FULL);

    // Load when empty, or when the held response leaves this cycle.
    assign can_load  = (state == EMPTY) || s_axi4_bready;
    // Reset blocks acceptance so nothing offered in a reset cycle is lost.
    assign load_fire = axi4_arstn && can_load && grant_any;

`ifdef RAB_B_ARB_FIXED_PRIO_EN
    // Fixed priority: lowest-index valid source wins (descending loop, last write wins).
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        for (int i = NUM_IN - 1; i >= 0; i--) begin
            if (m_axi4_bvalid[i]) begin
                grant_any = 1'b1;
                grant_idx = SRC_W'(i);
            end
        end
    end
`else
    logic [SRC_W-1:0] ptr;

    // Round-robin search starting at ptr; smallest distance from ptr wins.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        for (int k = NUM_IN - 1; k >= 0; k--) begin
            if (m_axi4_bvalid[(int'(ptr) + k) % NUM_IN]) begin
                grant_any = 1'b1;
                grant_idx = SRC_W'((int'(ptr) + k) % NUM_IN);
            end
        end
    end

    // Priority pointer moves just past the winner, only on a grant.
    always_ff @(posedge axi4_aclk) begin
        if (!axi4_arstn) begin
            ptr <= '0;
        end else if (load_fire) begin
            ptr <= (grant_idx == SRC_W'(NUM_IN - 1)) ? '0 : grant_idx + SRC_W'(1);
        end
    end
`endif

    // Payload mux for the granted source.
    always_comb begin
        sel_id   = '0;
        sel_resp = '0;
        sel_user = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (grant_idx == SRC_W'(i)) begin
                sel_id   = m_axi4_bid[i*AXI_ID_WIDTH +: AXI_ID_WIDTH];
                sel_resp = m_axi4_bresp[i*2 +: 2];
                sel_user = m_axi4_buser[i*AXI_USER_WIDTH +: AXI_USER_WIDTH];
            end
        end
    end

    // One-hot ready to the granted source, zero otherwise.
    always_comb begin
        m_axi4_bready = '0;
        if (load_fire) begin
            m_axi4_bready[grant_idx] = 1'b1;
        end
    end

    // Output register FSM: EMPTY/FULL with captured payload.
    always_ff @(posedge axi4_aclk) begin
        if (!axi4_arstn) begin
            state        <= EMPTY;
            s_axi4_bid   <= '0;
            s_axi4_bresp <= '0;
            s_axi4_buser <= '0;
            s_axi4_bsrc  <= '0;
        end else if (can_load) begin
            if (grant_any) begin
                state        <= FULL;
                s_axi4_bid   <= sel_id;
                s_axi4_bresp <= sel_resp;
                s_axi4_buser <= sel_user;
                s_axi4_bsrc  <= grant_idx;
            end else begin
                state <= EMPTY;
            end
        end
    end

endmodule

// File: tb/tb_axi4_b_arbiter.sv
// tb_axi4_b_arbiter: self-checking bench for axi4_b_arbiter with NUM_IN=4.
// Follows RAB_B_ARB_FIXED_PRIO_EN for the arbitration mode it expects.
module tb_axi4_b_arbiter;
  localparam int IDW = 4;
  localparam int USW = 4;
  localparam int N   = 4;
  localparam int SW  = 2;
  localparam int W   = SW + USW + 2 + IDW;

  logic             clk = 1'b0;
  logic             arstn = 1'b0;
  logic [N*IDW-1:0] m_bid = '0;
  logic [N*2-1:0]   m_bresp = '0;
  logic [N*USW-1:0] m_buser = '0;
  logic [N-1:0]     m_bvalid = '0;
  logic [N-1:0]     m_bready;
  logic [IDW-1:0]   s_bid;
  logic [1:0]       s_bresp;
  logic [USW-1:0]   s_buser;
  logic             s_bvalid;
  logic             s_bready = 1'b0;
  logic [SW-1:0]    s_bsrc;

  axi4_b_arbiter #(
    .AXI_ID_WIDTH(IDW),
    .AXI_USER_WIDTH(USW),
    .NUM_IN(N)
  ) dut (
    .axi4_aclk(clk),
    .axi4_arstn(arstn),
    .m_axi4_bid(m_bid),
    .m_axi4_bresp(m_bresp),
    .m_axi4_buser(m_buser),
    .m_axi4_bvalid(m_bvalid),
    .m_axi4_bready(m_bready),
    .s_axi4_bid(s_bid),
    .s_axi4_bresp(s_bresp),
    .s_axi4_buser(s_buser),
    .s_axi4_bvalid(s_bvalid),
    .s_axi4_bready(s_bready),
    .s_axi4_bsrc(s_bsrc)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard: entry = {src, user, resp, id}; the queue mirrors the output register
  logic [W-1:0] exp_q[$];
  int total = 0;
  int bad = 0;
  int m_ptr = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_src(input int i, input logic [IDW-1:0] id, input logic [1:0] resp,
                         input logic [USW-1:0] user);
    m_bid[i*IDW +: IDW]   = id;
    m_bresp[i*2 +: 2]     = resp;
    m_buser[i*USW +: USW] = user;
  endtask

  // reference pick: which source should be granted given current inputs
  function automatic int model_pick();
    if (!arstn) return -1;
    if (exp_q.size() != 0 && !s_bready) return -1;
    for (int k = 0; k < N; k++) begin
`ifdef RAB_B_ARB_FIXED_PRIO_EN
      int c = k;
`else
      int c = (m_ptr + k) % N;
`endif
      if (m_bvalid[c]) return c;
    end
    return -1;
  endfunction

  // one clock: check combinational ready and registered outputs, then advance model
  task automatic cycle();
    int g;
    logic [N-1:0] er;
    logic hs;
    logic [W-1:0] item;
    @(negedge clk);
    g = model_pick();
    er = '0;
    item = '0;
    if (g >= 0) begin
      er[g] = 1'b1;
      item = {SW'(g), m_buser[g*USW +: USW], m_bresp[g*2 +: 2], m_bid[g*IDW +: IDW]};
    end
    check("m_bready", 32'(m_bready), 32'(er));
    check("s_bvalid", 32'(s_bvalid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0)
      check("s_payload", 32'({s_bsrc, s_buser, s_bresp, s_bid}), 32'(exp_q[0]));
    hs = arstn && (exp_q.size() != 0) && s_bready;
    @(posedge clk);
    #1;
    if (!arstn) begin
      exp_q.delete();
      m_ptr = 0;
    end else begin
      if (hs) void'(exp_q.pop_front());
      if (g >= 0) begin
        exp_q.push_back(item);
        m_ptr = (g + 1) % N;
      end
    end
  endtask

  initial begin
    int exp_src;
    // default per-source payloads
    for (int i = 0; i < N; i++) set_src(i, IDW'(8 + i), 2'(i), USW'(12 - i));

    // reset held with all sources valid
    arstn = 1'b0;
    m_bvalid = '1;
    s_bready = 1'b1;
    @(posedge clk);
    #1;
    for (int c = 0; c < 3; c++) begin
      cycle();
      check("rst_bsrc", 32'(s_bsrc), 32'd0);
      check("rst_bvalid", 32'(s_bvalid), 32'd0);
    end

    // release: first grant goes to source 0
    arstn = 1'b1;
    cycle();
    check("first_grant_src", 32'(s_bsrc), 32'd0);
    check("first_grant_id", 32'(s_bid), 32'h8);

    // continuous traffic, one output per cycle
    for (int c = 0; c < 8; c++) begin
      cycle();
`ifdef RAB_B_ARB_FIXED_PRIO_EN
      exp_src = 0;
`else
      exp_src = (c + 1) % N;
`endif
      check("rr_seq_src", 32'(s_bsrc), 32'(exp_src));
      check("rr_seq_valid", 32'(s_bvalid), 32'd1);
    end

    // drain
    m_bvalid = '0;
    cycle();
    check("drain_empty", 32'(s_bvalid), 32'd0);

    // single source 1
    set_src(1, 4'hA, 2'b10, 4'h3);
    m_bvalid = 4'b0010;
    cycle();
    check("single_id", 32'(s_bid), 32'hA);
    check("single_resp", 32'(s_bresp), 32'h2);
    check("single_user", 32'(s_buser), 32'h3);
    check("single_src", 32'(s_bsrc), 32'd1);
    m_bvalid = '0;
    cycle();

    // backpressure: load bid=5 then stall with everyone valid
    set_src(0, 4'h5, 2'b01, 4'h7);
    m_bvalid = 4'b0001;
    s_bready = 1'b0;
    cycle();
    m_bvalid = '1;
    for (int c = 0; c < 4; c++) begin
      cycle();
      check("bp_hold_id", 32'(s_bid), 32'h5);
      check("bp_hold_valid", 32'(s_bvalid), 32'd1);
    end
    s_bready = 1'b1;
    m_bvalid = 4'b0011;
    cycle();
`ifdef RAB_B_ARB_FIXED_PRIO_EN
    check("bp_release_src", 32'(s_bsrc), 32'd0);
`else
    check("bp_release_src", 32'(s_bsrc), 32'd1);
`endif
    m_bvalid = '0;
    cycle();

    // simultaneous drain and fill: no bubble
    set_src(0, 4'h1, 2'b00, 4'h1);
    set_src(2, 4'h2, 2'b11, 4'h2);
    m_bvalid = 4'b0001;
    cycle();
    check("df_first_id", 32'(s_bid), 32'h1);
    m_bvalid = 4'b0100;
    cycle();
    check("df_second_id", 32'(s_bid), 32'h2);
    check("df_second_valid", 32'(s_bvalid), 32'd1);
    m_bvalid = 4'b1001;
    s_bready = 1'b1;
    // sources 0 and 3 contend
    for (int c = 0; c < 4; c++) begin
      cycle();
`ifdef RAB_B_ARB_FIXED_PRIO_EN
      check("fixed_prio_src", 32'(s_bsrc), 32'd0);
`endif
    end

    // reset mid-operation while full and offered
    m_bvalid = '1;
    s_bready = 1'b0;
    cycle();
    arstn = 1'b0;
    cycle();
    check("midrst_bvalid", 32'(s_bvalid), 32'd0);
    check("midrst_bsrc", 32'(s_bsrc), 32'd0);
    arstn = 1'b1;

    // random traffic
    for (int c = 0; c < 60; c++) begin
      for (int i = 0; i < N; i++)
        set_src(i, IDW'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), USW'($urandom_range(0, 15)));
      m_bvalid = N'($urandom_range(0, 15));
      s_bready = ($urandom_range(0, 3) != 0);
      cycle();
    end

    // final drain
    m_bvalid = '0;
    s_bready = 1'b1;
    cycle();
    cycle();
    check("final_empty", 32'(s_bvalid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
